// File: rtl/f_reg_pkg.sv
// f-register bank shared definitions.
// Sizes and the save/restore sequencer state encoding.
package f_reg_pkg;

  localparam int WIDTH  = 16;
  localparam int NREGS  = 16;
  localparam int DEPTH  = 16;
  localparam int SNAP_W = WIDTH * NREGS;
  localparam int DW     = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAVE = 2'd1,
    LOAD = 2'd2
  } state_t;

endpackage

// File: rtl/f_reg_seq.sv
// Call/return sequencer for the f-register bank.
// Tracks nesting depth and flags overflow, underflow and conflicts.
module f_reg_seq
  import f_reg_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic call,
  input  logic ret,
  input  logic restore_valid,
  output logic backup,
  output logic restore,
  output logic busy,
  output logic load_en,
  output logic wr_block,
  output logic ovf,
  output logic unf,
  output logic err
);

  state_t        state;
  logic [DW-1:0] depth;

  logic call_only;
  logic ret_only;
  logic full;
  logic empty;

  assign call_only = call && !ret;
  assign ret_only  = ret && !call;
  assign full      = (depth == DW'(DEPTH));
  assign empty     = (depth == '0);

  // Load happens on the edge where the popped image is presented.
  assign load_en  = (state == LOAD) && restore_valid && !reset;
  assign wr_block = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      depth   <= '0;
      backup  <= 1'b0;
      restore <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (call && ret) begin
            err <= 1'b1;
          end else if (call_only && !full) begin
            state  <= SAVE;
            backup <= 1'b1;
            busy   <= 1'b1;
          end else if (call_only) begin
            ovf <= 1'b1;
          end else if (ret_only && !empty) begin
            state   <= LOAD;
            restore <= 1'b1;
            busy    <= 1'b1;
          end else if (ret_only) begin
            unf <= 1'b1;
          end
        end
        SAVE: begin
          state  <= IDLE;
          backup <= 1'b0;
          busy   <= 1'b0;
          depth  <= depth + 1'b1;
        end
        LOAD: begin
          if (restore_valid) begin
            state   <= IDLE;
            restore <= 1'b0;
            busy    <= 1'b0;
            depth   <= depth - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          backup  <= 1'b0;
          restore <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/f_reg_bank.sv
// f-register bank: 16x16 array, two read ports, one write port,
// with call/return snapshot save and restore through the backup stage.
module f_reg_bank
  import f_reg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        rs_addr,
  input  logic [3:0]        rt_addr,
  output logic [WIDTH-1:0]  rs_data,
  output logic [WIDTH-1:0]  rt_data,
  input  logic              we,
  input  logic [3:0]        wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              call,
  input  logic              ret,
  output logic              busy,
  output logic              backup,
  output logic              restore,
  output logic [SNAP_W-1:0] snap_out,
  input  logic [SNAP_W-1:0] snap_in,
  input  logic              restore_valid,
  output logic              ovf,
  output logic              unf,
  output logic              err
);

  logic [WIDTH-1:0] regs [NREGS];
  logic             load_en;
  logic             wr_block;

  f_reg_seq u_seq (
    .clk           (clk),
    .reset         (reset),
    .call          (call),
    .ret           (ret),
    .restore_valid (restore_valid),
    .backup        (backup),
    .restore       (restore),
    .busy          (busy),
    .load_en       (load_en),
    .wr_block      (wr_block),
    .ovf           (ovf),
    .unf           (unf),
    .err           (err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (load_en) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= snap_in[WIDTH*i +: WIDTH];
    end else if (we && !wr_block) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];

  always_comb begin
    snap_out = '0;
    for (int i = 0; i < NREGS; i++)
      snap_out[WIDTH*i +: WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_f_reg_bank.sv
// Directed bench for f_reg_bank: reads/writes, save, restore,
// depth limits, conflicts and reset during restore.
module tb_f_reg_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   rs_addr, rt_addr;
  logic [15:0]  rs_data, rt_data;
  logic         we;
  logic [3:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         call, ret;
  logic         busy, backup, restore;
  logic [255:0] snap_out, snap_in;
  logic         restore_valid;
  logic         ovf, unf, err;

  int n_chk  = 0;
  int n_fail = 0;

  f_reg_bank dut (
    .clk           (clk),
    .reset         (reset),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .we            (we),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .call          (call),
    .ret           (ret),
    .busy          (busy),
    .backup        (backup),
    .restore       (restore),
    .snap_out      (snap_out),
    .snap_in       (snap_in),
    .restore_valid (restore_valid),
    .ovf           (ovf),
    .unf           (unf),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] ers;
    logic [15:0] ert;
  } vec_t;

  vec_t         vt [16];
  logic [255:0] img;
  logic [255:0] saved;
  int           pulses;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; rs_addr = '0; rt_addr = '0;
    we = 1'b0; wr_addr = '0; wr_data = '0;
    call = 1'b0; ret = 1'b0;
    snap_in = '0; restore_valid = 1'b0;
    step; step;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_backup", 256'(backup), 256'(0));
    chk("rst_restore", 256'(restore), 256'(0));
    chk("rst_flags", 256'({ovf, unf, err}), 256'(0));
    chk("rst_snap", snap_out, '0);
    reset = 1'b0;

    // write reg i = 0x1000+i, visible the cycle after the write
    img = '0;
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wr_addr = 4'(i); wr_data = 16'h1000 + 16'(i);
      rs_addr = 4'(i);
      #1;
      if (i == 0) chk("no_bypass", 256'(rs_data), 256'(0));
      step;
      chk("wr_visible", 256'(rs_data), 256'(16'h1000 + 16'(i)));
      img[16*i +: 16] = 16'h1000 + 16'(i);
    end
    we = 1'b0;

    for (int i = 0; i < 16; i++) begin
      vt[i].rs  = 4'(i);
      vt[i].rt  = 4'(15 - i);
      vt[i].ers = 16'h1000 + 16'(i);
      vt[i].ert = 16'h1000 + 16'(15 - i);
    end
    for (int i = 0; i < 16; i++) begin
      rs_addr = vt[i].rs; rt_addr = vt[i].rt;
      #1;
      chk("rd_rs", 256'(rs_data), 256'(vt[i].ers));
      chk("rd_rt", 256'(rt_data), 256'(vt[i].ert));
    end
    chk("snap_flat", snap_out, img);

    // call with a same-cycle write to reg 3
    call = 1'b1; we = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
    #1;
    chk("call_bk_early", 256'(backup), 256'(0));
    step;
    call = 1'b0;
    img[63:48] = 16'hBEEF;
    saved = img;
    chk("save_backup", 256'(backup), 256'(1));
    chk("save_busy", 256'(busy), 256'(1));
    chk("save_snap3", 256'(snap_out[63:48]), 256'(16'hBEEF));
    chk("save_image", snap_out, saved);
    // write during SAVE is dropped
    wr_addr = 4'd7; wr_data = 16'h7777;
    step;
    we = 1'b0;
    chk("save_end_bk", 256'(backup), 256'(0));
    chk("save_end_busy", 256'(busy), 256'(0));
    rs_addr = 4'd7; #1;
    chk("save_we_drop", 256'(rs_data), 256'(16'h1007));

    // clear bank
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wr_addr = 4'(i); wr_data = '0;
      step;
    end
    we = 1'b0;
    chk("cleared", snap_out, '0);

    // ret with restore_valid delayed three cycles
    ret = 1'b1;
    step;
    ret = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      chk("load_restore", 256'(restore), 256'(1));
      if (restore) pulses++;
      if (k == 1) begin
        rs_addr = 4'd5; #1;
        chk("load_we_drop", 256'(rs_data), 256'(0));
      end
      we = (k == 0); wr_addr = 4'd5; wr_data = 16'hDEAD;
      restore_valid = (k == 3);
      snap_in = saved;
      step;
    end
    we = 1'b0; restore_valid = 1'b0;
    chk("restore_cycles", 256'(pulses), 256'(4));
    chk("load_done_rs", 256'(restore), 256'(0));
    chk("load_done_busy", 256'(busy), 256'(0));
    chk("restored", snap_out, saved);

    // depth now 0: ret underflows
    ret = 1'b1;
    step;
    ret = 1'b0;
    chk("unf_no_restore", 256'(restore), 256'(0));
    chk("unf_set", 256'(unf), 256'(1));

    // 16 calls then a 17th
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      call = 1'b1;
      step;
      call = 1'b0;
      if (backup) pulses++;
      step;
    end
    chk("push16", 256'(pulses), 256'(16));
    chk("ovf_pre", 256'(ovf), 256'(0));
    call = 1'b1;
    step;
    call = 1'b0;
    chk("ovf_no_bk", 256'(backup), 256'(0));
    chk("ovf_busy", 256'(busy), 256'(0));
    chk("ovf_set", 256'(ovf), 256'(1));

    // call and ret together
    call = 1'b1; ret = 1'b1;
    step;
    call = 1'b0; ret = 1'b0;
    chk("conf_err", 256'(err), 256'(1));
    chk("conf_nobr", 256'({backup, restore}), 256'(0));
    step;
    chk("conf_err_pulse", 256'(err), 256'(0));

    // ret at depth 16, reset two cycles into LOAD
    ret = 1'b1;
    step;
    ret = 1'b0;
    chk("ld2_restore", 256'(restore), 256'(1));
    step;
    chk("ld2_restore2", 256'(restore), 256'(1));
    reset = 1'b1; restore_valid = 1'b1; snap_in = '1;
    step;
    reset = 1'b0; restore_valid = 1'b0;
    chk("rstld_restore", 256'(restore), 256'(0));
    chk("rstld_busy", 256'(busy), 256'(0));
    chk("rstld_flags", 256'({ovf, unf}), 256'(0));
    chk("rstld_regs", snap_out, '0);
    // depth back to 0: ret underflows
    ret = 1'b1;
    step;
    ret = 1'b0;
    chk("rstld_depth0", 256'(restore), 256'(0));
    chk("rstld_unf", 256'(unf), 256'(1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
